// File: rtl/spbram_stream_reader.sv
// Streams len words from a single-port BRAM starting at base_addr (wrapping at MEM_SIZE), m_last on the final word.
// Latency: first m_valid 2 clks after the accepted start; 1 word/clk sustained while m_ready is high.
// Backpressure: 2-entry skid FIFO absorbs the RAM read latency; reads stall on m_ready low. SPBRAM_RD_CHKSUM_EN adds chksum.
module spbram_stream_reader #(
    parameter int DWIDTH   = 16,
    parameter int AWIDTH   = 12,
    parameter int MEM_SIZE = 3840
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] mem_addr0,
    output logic              mem_ce0,
    output logic              mem_we0,
    input  logic [DWIDTH-1:0] mem_q0,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
`ifdef SPBRAM_RD_CHKSUM_EN
    output logic [DWIDTH-1:0] chksum,
`endif
    output logic              m_last
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam logic [AWIDTH-1:0] PTR_MAX = AWIDTH'(MEM_SIZE - 1);

    state_t              state_q, state_d;
    logic [AWIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AWIDTH-1:0]   issued_q, issued_d;
    logic [AWIDTH-1:0]   len_q, len_d;
    logic                inflight_q, inflight_last_q;
    logic [DWIDTH-1:0]   fifo_dat_q [2];
    logic                fifo_last_q [2];
    logic                wr_idx_q, rd_idx_q;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [1:0]          occ;
    logic                start_acc, pop, push, issue_last;

    assign start_acc  = (state_q == S_IDLE) && start;
    assign push       = inflight_q;
    assign pop        = m_valid && m_ready;
    assign issue_last = (issued_q == len_q - 1'b1);
    // Occupancy after this cycle's pop, counting the read already in flight.
    assign occ        = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};

    assign m_valid   = (fifo_cnt_q != 2'd0);
    assign m_data    = fifo_dat_q[rd_idx_q];
    assign m_last    = m_valid && fifo_last_q[rd_idx_q];
    assign mem_addr0 = rd_ptr_q;
    assign mem_we0   = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (len == '0) ? S_FIN : S_RUN;
            S_RUN:   if (mem_ce0 && issue_last) state_d = S_DRAIN;
            S_DRAIN: if (pop && m_last) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_FIN);
        mem_ce0 = (state_q == S_RUN) && (issued_q < len_q) && (occ < 2'd2);
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        issued_d   = issued_q;
        len_d      = len_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        if (start_acc) begin
            rd_ptr_d = base_addr;
            issued_d = '0;
            len_d    = len;
        end else if (mem_ce0) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            issued_d = issued_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q        <= '0;
            issued_q        <= '0;
            len_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_cnt_q      <= '0;
            wr_idx_q        <= 1'b0;
            rd_idx_q        <= 1'b0;
            fifo_dat_q[0]   <= '0;
            fifo_dat_q[1]   <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
        end else begin
            rd_ptr_q        <= rd_ptr_d;
            issued_q        <= issued_d;
            len_q           <= len_d;
            inflight_q      <= mem_ce0;
            inflight_last_q <= mem_ce0 && issue_last;
            fifo_cnt_q      <= fifo_cnt_d;
            if (push) begin
                fifo_dat_q[wr_idx_q]  <= mem_q0;
                fifo_last_q[wr_idx_q] <= inflight_last_q;
                wr_idx_q              <= ~wr_idx_q;
            end
            if (pop) rd_idx_q <= ~rd_idx_q;
        end
    end

`ifdef SPBRAM_RD_CHKSUM_EN
    logic [DWIDTH-1:0] chksum_q, chksum_d;

    always_comb begin
        chksum_d = chksum_q;
        if (start_acc) chksum_d = '0;
        else if (pop)  chksum_d = chksum_q + m_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chksum_q <= '0;
        else        chksum_q <= chksum_d;
    end

    assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_spbram_stream_reader.sv
// Bench for spbram_stream_reader: RAM model, randomized transfers, reference queue built from (base+i) mod MEM_SIZE.
module tb_spbram_stream_reader;
    localparam int DW = 16, AW = 12, MS = 3840;

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] base_addr = '0, len = '0, mem_addr0;
    logic          busy, done, mem_ce0, mem_we0, m_valid, m_last;
    logic [DW-1:0] mem_q0, m_data;
`ifdef SPBRAM_RD_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    spbram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .mem_addr0(mem_addr0), .mem_ce0(mem_ce0),
        .mem_we0(mem_we0), .mem_q0(mem_q0), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data),
`ifdef SPBRAM_RD_CHKSUM_EN
        .chksum(chksum),
`endif
        .m_last(m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [MS];
    always @(posedge clk) if (mem_ce0) mem_q0 <= ram[mem_addr0];

    int total = 0, bad = 0, cyc = 0, rdy_mode = 0;
    logic [DW-1:0] got_dat[$], exp_dat[$];
    bit            got_last[$], exp_last[$];
    int            hs_cyc[$], addr_log[$], done_cyc[$];
    int            first_vld, vld_cnt, viol, stall_viol, issued_n, popped_n;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ~m_ready;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Passive monitor: logs handshakes, reads and done pulses; flags overfill and unstable stalls.
    initial begin
        bit hs, prev_stall, prev_last;
        logic [DW-1:0] prev_dat;
        prev_stall = 0; prev_last = 0; prev_dat = '0; issued_n = 0; popped_n = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                issued_n = 0; popped_n = 0; prev_stall = 0;
            end else begin
                hs = m_valid && m_ready;
                if (mem_ce0 && (issued_n - popped_n - int'(hs)) >= 2) viol++;
                if (prev_stall && (!m_valid || m_data !== prev_dat || m_last !== prev_last)) stall_viol++;
                if (m_valid) begin
                    vld_cnt++;
                    if (first_vld < 0) first_vld = cyc;
                end
                if (mem_ce0) begin
                    addr_log.push_back(int'(mem_addr0));
                    issued_n++;
                end
                if (hs) begin
                    got_dat.push_back(m_data);
                    got_last.push_back(m_last);
                    hs_cyc.push_back(cyc);
                    popped_n++;
                end
                if (done) done_cyc.push_back(cyc);
                prev_stall = m_valid && !m_ready;
                prev_dat = m_data;
                prev_last = m_last;
            end
        end
    end

    task automatic clear_logs();
        got_dat.delete(); got_last.delete(); hs_cyc.delete(); addr_log.delete(); done_cyc.delete();
        first_vld = -1; vld_cnt = 0; viol = 0; stall_viol = 0;
    endtask

    function automatic void build_exp(input int b, input int l);
        exp_dat.delete(); exp_last.delete();
        for (int i = 0; i < l; i++) begin
            exp_dat.push_back(ram[(b + i) % MS]);
            exp_last.push_back(i == l - 1);
        end
    endfunction

    task automatic pulse_start(input int b, input int l, output int s_edge);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'(b); len = AW'(l);
        s_edge = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0; base_addr = AW'($urandom); len = AW'($urandom);
    endtask

    task automatic wait_done(input string name);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #1;
            if (done_cyc.size() > 0) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL %s_timeout: no done within 400 clks", name); end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, mem_ce0, mem_we0, m_valid, m_last} !== 6'b0 || mem_addr0 !== '0 || m_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b ce=%b we=%b vld=%b last=%b addr=%0d data=%h, want all 0",
                     busy, done, mem_ce0, mem_we0, m_valid, m_last, mem_addr0, m_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: busy=%b vld=%b want 0 0", busy, m_valid);
        end
    endtask

    task automatic test_basic();
        int s;
        for (int i = 0; i < 4; i++) ram[16 + i] = DW'(16 + i);
        rdy_mode = 0; clear_logs(); build_exp(16, 4);
        pulse_start(16, 4, s);
        wait_done("basic");
        total++;
        if (first_vld !== s + 2) begin bad++; $display("FAIL basic_first_valid: cyc %0d want %0d", first_vld, s + 2); end
        total++;
        if (got_dat.size() !== 4) begin
            bad++; $display("FAIL basic_count: got %0d words want 4", got_dat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i] || hs_cyc[i] !== s + 2 + i) begin
                    bad++;
                    $display("FAIL basic_word%0d: data=%h last=%b cyc=%0d want data=%h last=%b cyc=%0d",
                             i, got_dat[i], got_last[i], hs_cyc[i], exp_dat[i], exp_last[i], s + 2 + i);
                end
            end
            total++;
            if (done_cyc.size() !== 1 || done_cyc[0] !== hs_cyc[3] + 1) begin
                bad++; $display("FAIL basic_done: %0d pulses first at %0d want 1 at %0d",
                                done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, hs_cyc[3] + 1);
            end
        end
    endtask

    task automatic test_wrap();
        int s;
        int want[4] = '{3838, 3839, 0, 1};
        for (int i = 0; i < 4; i++) ram[want[i]] = DW'($urandom);
        rdy_mode = 2; clear_logs(); build_exp(3838, 4);
        pulse_start(3838, 4, s);
        wait_done("wrap");
        total++;
        if (addr_log.size() !== 4) begin
            bad++; $display("FAIL wrap_reads: got %0d reads want 4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (addr_log[i] !== want[i]) begin bad++; $display("FAIL wrap_addr%0d: got %0d want %0d", i, addr_log[i], want[i]); end
            end
        end
        total++;
        if (got_dat.size() !== 4 || got_dat[0] !== exp_dat[0] || got_dat[1] !== exp_dat[1] ||
            got_dat[2] !== exp_dat[2] || got_dat[3] !== exp_dat[3]) begin
            bad++; $display("FAIL wrap_data: got %0d words, want %h %h %h %h", got_dat.size(),
                            exp_dat[0], exp_dat[1], exp_dat[2], exp_dat[3]);
        end
    endtask

    task automatic test_random_xfers(input string name, input int mode, input int iters);
        int s, b, l;
        for (int it = 0; it < iters; it++) begin
            b = $urandom_range(0, MS - 1);
            l = (mode == 1) ? 8 : $urandom_range(1, 20);
            for (int i = 0; i < l; i++) ram[(b + i) % MS] = DW'($urandom);
            rdy_mode = mode; clear_logs(); build_exp(b, l);
            pulse_start(b, l, s);
            wait_done(name);
            total++;
            if (got_dat.size() !== l) begin
                bad++; $display("FAIL %s_count: base=%0d got %0d words want %0d", name, b, got_dat.size(), l);
            end else begin
                for (int i = 0; i < l; i++) begin
                    total++;
                    if (got_dat[i] !== exp_dat[i] || got_last[i] !== exp_last[i]) begin
                        bad++; $display("FAIL %s_word%0d: data=%h last=%b want %h %b", name, i,
                                        got_dat[i], got_last[i], exp_dat[i], exp_last[i]);
                    end
                end
            end
            total++;
            if (viol !== 0 || stall_viol !== 0 || done_cyc.size() !== 1) begin
                bad++; $display("FAIL %s_rules: overfill=%0d unstable=%0d done_pulses=%0d want 0 0 1",
                                name, viol, stall_viol, done_cyc.size());
            end
        end
    endtask

    task automatic test_len0();
        int s;
        rdy_mode = 0; clear_logs();
        pulse_start(5, 0, s);
        wait_done("len0");
        total++;
        if (addr_log.size() !== 0 || vld_cnt !== 0 || done_cyc.size() !== 1 || done_cyc[0] !== s) begin
            bad++; $display("FAIL len0: reads=%0d valids=%0d dones=%0d at %0d want 0 0 1 at %0d",
                            addr_log.size(), vld_cnt, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, s);
        end
    endtask

    task automatic test_restart();
        int s, s2;
        for (int i = 0; i < 6; i++) ram[200 + i] = DW'($urandom);
        rdy_mode = 0; clear_logs(); build_exp(200, 6);
        pulse_start(200, 6, s);
        pulse_start(900, 2, s2);
        wait_done("restart");
        total++;
        if (got_dat.size() !== 6 || got_dat[0] !== exp_dat[0] || got_dat[5] !== exp_dat[5] || done_cyc.size() !== 1) begin
            bad++; $display("FAIL restart: words=%0d dones=%0d want 6 words from base 200 and 1 done",
                            got_dat.size(), done_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        int s;
        bit ok = 0;
        rdy_mode = 0; clear_logs();
        pulse_start(40, 8, s);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (got_dat.size() >= 3) begin ok = 1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_wait: only %0d words seen", got_dat.size()); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, mem_ce0, m_valid, m_last} !== 5'b0 || mem_addr0 !== '0 || m_data !== '0) begin
            bad++; $display("FAIL midreset_outputs: busy=%b done=%b ce=%b vld=%b last=%b addr=%0d data=%h want all 0",
                            busy, done, mem_ce0, m_valid, m_last, mem_addr0, m_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (done_cyc.size() !== 0 || busy !== 1'b0) begin
            bad++; $display("FAIL midreset_nodone: dones=%0d busy=%b want 0 0", done_cyc.size(), busy);
        end
        test_random_xfers("after_reset", 2, 1);
    endtask

`ifdef SPBRAM_RD_CHKSUM_EN
    task automatic test_chksum();
        int s;
        ram[100] = 16'hFFFF; ram[101] = 16'h0002;
        rdy_mode = 2; clear_logs();
        pulse_start(100, 2, s);
        wait_done("chksum");
        total++;
        if (chksum !== 16'h0001) begin bad++; $display("FAIL chksum: got %h want 0001", chksum); end
    endtask
`endif

    initial begin
        for (int i = 0; i < MS; i++) ram[i] = DW'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_random_xfers("toggle", 1, 2);
        test_random_xfers("random", 2, 12);
        test_len0();
        test_restart();
        test_reset_mid();
`ifdef SPBRAM_RD_CHKSUM_EN
        test_chksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
